// File: rtl/grf_wb_queue.sv
// Writeback-side GRF write queue: FIFO of pending register writes drained one per cycle,
// with a combinational youngest-match lookup. Define GRF_WB_TRACE_EN to print each issued write.
module grf_wb_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [4:0]                 in_addr,
   input  logic [31:0]                in_data,
   input  logic [31:0]                in_pc,
   input  logic                       drain_en,
   output logic                       grf_we,
   output logic [4:0]                 grf_a3,
   output logic [31:0]                grf_wd,
   output logic [31:0]                grf_pc,
   input  logic [4:0]                 chk_addr,
   output logic                       chk_pending,
   output logic [31:0]                chk_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pc;
   } wb_entry_t;

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             grf_we_q, grf_we_d;
   logic [4:0]       grf_a3_q, grf_a3_d;
   logic [31:0]      grf_wd_q, grf_wd_d;
   logic [31:0]      grf_pc_q, grf_pc_d;
   logic             push, pop;
   wb_entry_t        head;

   assign in_ready = rst && (count_q < CNT_W'(DEPTH));
   // Writes to $0 complete the handshake but are dropped here.
   assign push     = in_valid && in_ready && (in_addr != 5'd0);
   assign pop      = drain_en && (count_q != '0);
   assign head     = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      grf_we_d = 1'b0;
      grf_a3_d = grf_a3_q;
      grf_wd_d = grf_wd_q;
      grf_pc_d = grf_pc_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{addr: in_addr, data: in_data, pc: in_pc};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         grf_we_d = 1'b1;
         grf_a3_d = head.addr;
         grf_wd_d = head.data;
         grf_pc_d = head.pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         grf_we_q <= 1'b0;
         grf_a3_q <= '0;
         grf_wd_q <= '0;
         grf_pc_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         grf_we_q <= grf_we_d;
         grf_a3_q <= grf_a3_d;
         grf_wd_q <= grf_wd_d;
         grf_pc_q <= grf_pc_d;
`ifdef GRF_WB_TRACE_EN
         if (pop) $display("@%h: $%d <= %h", head.pc, head.addr, head.data);
`endif
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Walk oldest to youngest so the last match wins; the issue register is older than any entry.
   always_comb begin
      chk_pending = 1'b0;
      chk_data    = '0;
      if (grf_we_q && (grf_a3_q == chk_addr)) begin
         chk_pending = 1'b1;
         chk_data    = grf_wd_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count_q) &&
             (mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))].addr == chk_addr)) begin
            chk_pending = 1'b1;
            chk_data    = mem_q[PTR_W'(rd_ptr_q + PTR_W'(i))].data;
         end
      end
      if (chk_addr == 5'd0) begin
         chk_pending = 1'b0;
         chk_data    = '0;
      end
   end

   assign grf_we = grf_we_q;
   assign grf_a3 = grf_a3_q;
   assign grf_wd = grf_wd_q;
   assign grf_pc = grf_pc_q;
   assign count  = count_q;

endmodule
